// File: rtl/key_event_pkg.sv
// key_event_pkg: shared types and constants for the key event generator.
//   state_t           - FSM state encoding (IDLE, PRESSED, HELD)
//   HOLD_CYCLES_DEF   - default cycles from press to hold event
//   REPEAT_CYCLES_DEF - default auto-repeat period while held
//   COUNT_W           - width of the wrapping press counter
package key_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    localparam int unsigned HOLD_CYCLES_DEF   = 25_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF = 5_000_000;
    localparam int unsigned COUNT_W           = 8;

endpackage

// File: rtl/key_timer.sv
// key_timer: CNT_W-bit up counter used by key_event for hold/repeat timing.
//   clock     in  : system clock, rising edge
//   reset     in  : asynchronous, active-low
//   load_zero in  : synchronous load of zero (wins over enable)
//   enable    in  : increment by one
//   terminal  in  : compare value
//   tc        out : combinational, high while count == terminal
module key_timer #(
    parameter int unsigned CNT_W = 27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_zero,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic             tc
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_zero) begin
            value_d = '0;
        end else if (enable) begin
            value_d = value_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign tc = (value_q == terminal);

endmodule

// File: rtl/key_event.sv
// key_event: turns the filtered, clock-synchronous key level into one-cycle
// press/release/hold/auto-repeat events and a wrapping press counter.
//   clock       in  : system clock, rising edge
//   reset       in  : asynchronous, active-low
//   level_in    in  : filtered key level, 1 = pressed
//   clear       in  : synchronous clear of count (a same-edge press gives 1)
//   press       out : one-cycle pulse on press
//   release_evt out : one-cycle pulse on release ("release" is a reserved word)
//   hold        out : one-cycle pulse when the press becomes a long press
//   rpt         out : one-cycle auto-repeat pulse
//   pressed     out : high while the FSM is not IDLE
//   count       out : number of presses modulo 256
// Build option: define KEY_EVENT_REPEAT_EN to enable auto-repeat in HELD;
// otherwise HELD is terminal until release, the timer stops, rpt stays 0.
module key_event
    import key_event_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int unsigned CNT_W         = 27
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               level_in,
    input  logic               clear,
    output logic               press,
    output logic               release_evt,
    output logic               hold,
    output logic               rpt,
    output logic               pressed,
    output logic [COUNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

    state_t             state_q, state_d;
    logic               level_q;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               hold_q, hold_d;
    logic               rpt_q, rpt_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               rise, fall;
    logic               tmr_load, tmr_en, tmr_tc;
    logic [CNT_W-1:0]   tmr_term;

    assign rise = level_in & ~level_q;
    assign fall = ~level_in & level_q;

    // The terminal only matters in PRESSED and HELD; IDLE ignores tc.
    assign tmr_term = (state_q == ST_PRESSED) ? HOLD_TERM : REPEAT_TERM;

    key_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .load_zero (tmr_load),
        .enable    (tmr_en),
        .terminal  (tmr_term),
        .tc        (tmr_tc)
    );

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        hold_d    = 1'b0;
        rpt_d     = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        // Clear first, so a press on the same edge lands on 1.
        count_d   = clear ? '0 : count_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d  = ST_PRESSED;
                    press_d  = 1'b1;
                    tmr_load = 1'b1;
                    count_d  = count_d + COUNT_W'(1);
                end
            end
            ST_PRESSED: begin
                // Fall is checked first so it suppresses a coincident hold.
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    tmr_load  = 1'b1;
                end else if (tmr_tc) begin
                    state_d  = ST_HELD;
                    hold_d   = 1'b1;
                    tmr_load = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    tmr_load  = 1'b1;
                end
`ifdef KEY_EVENT_REPEAT_EN
                else if (tmr_tc) begin
                    rpt_d    = 1'b1;
                    tmr_load = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
`endif
            end
            default: begin
                state_d  = ST_IDLE;
                tmr_load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;
            rpt_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_in;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            rpt_q     <= rpt_d;
            count_q   <= count_d;
        end
    end

    assign press       = press_q;
    assign release_evt = release_q;
    assign hold        = hold_q;
    assign rpt         = rpt_q;
    assign pressed     = (state_q != ST_IDLE);
    assign count       = count_q;

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed self-checking bench for key_event with
// HOLD_CYCLES=8, REPEAT_CYCLES=4. Expectations follow the build option
// KEY_EVENT_REPEAT_EN when it is defined for the compile.
module tb_key_event;

    localparam int unsigned HOLD   = 8;
    localparam int unsigned REPEAT = 4;
`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       level_in;
    logic       clear;
    logic       press;
    logic       release_evt;
    logic       hold;
    logic       rpt;
    logic       pressed;
    logic [7:0] count;
    logic [4:0] ev;

    int checks = 0;
    int errors = 0;

    key_event #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REPEAT),
        .CNT_W         (27)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .level_in    (level_in),
        .clear       (clear),
        .press       (press),
        .release_evt (release_evt),
        .hold        (hold),
        .rpt         (rpt),
        .pressed     (pressed),
        .count       (count)
    );

    // Event vector: {press, release, hold, rpt, pressed}
    assign ev = {press, release_evt, hold, rpt, pressed};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge; inputs change and outputs
    // are sampled there, well away from the following edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        level_in = 1'b0;
        clear    = 1'b0;
        tick();
        tick();
        checks++;
        if (ev !== 5'b00000) begin
            errors++;
            $display("FAIL reset_events: got %b expected %b", ev, 5'b00000);
        end
        checks++;
        if (count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected %0d", count, 0);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (ev !== 5'b00000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected %b", ev, 5'b00000);
        end
    endtask

    task automatic test_press();
        level_in = 1'b1;
        tick();
        checks++;
        if (ev !== 5'b10001 || count !== 8'd1) begin
            errors++;
            $display("FAIL press_pulse: got ev=%b count=%0d expected ev=%b count=%0d", ev, count, 5'b10001, 1);
        end
        tick();
        checks++;
        if (ev !== 5'b00001) begin
            errors++;
            $display("FAIL press_one_cycle: got %b expected %b", ev, 5'b00001);
        end
        level_in = 1'b0;
        tick();
        checks++;
        if (ev !== 5'b01000) begin
            errors++;
            $display("FAIL release_pulse: got %b expected %b", ev, 5'b01000);
        end
        tick();
        checks++;
        if (ev !== 5'b00000) begin
            errors++;
            $display("FAIL release_one_cycle: got %b expected %b", ev, 5'b00000);
        end
    endtask

    task automatic test_hold_repeat();
        logic [4:0] exp_ev;
        level_in = 1'b1;
        tick();
        checks++;
        if (ev !== 5'b10001 || count !== 8'd2) begin
            errors++;
            $display("FAIL hr_press: got ev=%b count=%0d expected ev=%b count=%0d", ev, count, 5'b10001, 2);
        end
        for (int i = 1; i <= 30; i++) begin
            tick();
            exp_ev = {1'b0, 1'b0, (i == 8), (REP && i > 8 && ((i - 8) % 4) == 0), 1'b1};
            checks++;
            if (ev !== exp_ev) begin
                errors++;
                $display("FAIL hold_repeat_cycle%0d: got %b expected %b", i, ev, exp_ev);
            end
        end
        level_in = 1'b0;
        tick();
        checks++;
        if (ev !== 5'b01000) begin
            errors++;
            $display("FAIL hr_release: got %b expected %b", ev, 5'b01000);
        end
        tick();
        checks++;
        if (ev !== 5'b00000) begin
            errors++;
            $display("FAIL hr_idle: got %b expected %b", ev, 5'b00000);
        end
    endtask

    // Level drops on the edge where hold would fire: release wins.
    task automatic test_fall_on_hold();
        level_in = 1'b1;
        tick();
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (ev !== 5'b00001) begin
                errors++;
                $display("FAIL foh_wait%0d: got %b expected %b", i, ev, 5'b00001);
            end
        end
        level_in = 1'b0;
        tick();
        checks++;
        if (ev !== 5'b01000) begin
            errors++;
            $display("FAIL foh_release_only: got %b expected %b", ev, 5'b01000);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (ev !== 5'b00000) begin
                errors++;
                $display("FAIL foh_quiet%0d: got %b expected %b", i, ev, 5'b00000);
            end
        end
    endtask

    // Level drops on the edge where the first repeat would fire.
    task automatic test_fall_on_repeat();
        logic [4:0] exp_ev;
        level_in = 1'b1;
        tick();
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp_ev = {1'b0, 1'b0, (i == 8), 1'b0, 1'b1};
            checks++;
            if (ev !== exp_ev) begin
                errors++;
                $display("FAIL for_wait%0d: got %b expected %b", i, ev, exp_ev);
            end
        end
        level_in = 1'b0;
        tick();
        checks++;
        if (ev !== 5'b01000) begin
            errors++;
            $display("FAIL for_release_only: got %b expected %b", ev, 5'b01000);
        end
        tick();
        checks++;
        if (ev !== 5'b00000) begin
            errors++;
            $display("FAIL for_quiet: got %b expected %b", ev, 5'b00000);
        end
    endtask

    task automatic test_wrap_clear();
        logic [7:0] exp_cnt;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (count !== 8'd0) begin
            errors++;
            $display("FAIL clear_count: got %0d expected %0d", count, 0);
        end
        for (int p = 1; p <= 257; p++) begin
            level_in = 1'b1;
            tick();
            exp_cnt = 8'(p % 256);
            checks++;
            if (count !== exp_cnt || press !== 1'b1) begin
                errors++;
                $display("FAIL wrap_press%0d: got count=%0d press=%b expected count=%0d press=1", p, count, press, exp_cnt);
            end
            level_in = 1'b0;
            tick();
        end
        for (int p = 0; p < 3; p++) begin
            level_in = 1'b1;
            tick();
            level_in = 1'b0;
            tick();
        end
        checks++;
        if (count !== 8'd4) begin
            errors++;
            $display("FAIL count_before_clear: got %0d expected %0d", count, 4);
        end
        clear    = 1'b1;
        level_in = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (count !== 8'd1 || press !== 1'b1) begin
            errors++;
            $display("FAIL clear_with_press: got count=%0d press=%b expected count=1 press=1", count, press);
        end
        level_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_held();
        level_in = 1'b1;
        tick();
        for (int i = 1; i <= 10; i++) tick();
        checks++;
        if (pressed !== 1'b1) begin
            errors++;
            $display("FAIL rh_in_held: got pressed=%b expected 1", pressed);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (ev !== 5'b00000 || count !== 8'd0) begin
            errors++;
            $display("FAIL rh_async_reset: got ev=%b count=%0d expected ev=%b count=0", ev, count, 5'b00000);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ev !== 5'b00000) begin
                errors++;
                $display("FAIL rh_no_release%0d: got %b expected %b", i, ev, 5'b00000);
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (ev !== 5'b10001 || count !== 8'd1) begin
            errors++;
            $display("FAIL rh_press_after_reset: got ev=%b count=%0d expected ev=%b count=1", ev, count, 5'b10001);
        end
        level_in = 1'b0;
        tick();
        checks++;
        if (ev !== 5'b01000) begin
            errors++;
            $display("FAIL rh_release: got %b expected %b", ev, 5'b01000);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_hold_repeat();
        test_fall_on_hold();
        test_fall_on_repeat();
        test_wrap_clear();
        test_reset_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
